// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID-stage hazard, branch-flush and memory-freeze control
// Build option: define HAZARD_FORWARD_EN to limit hazard detection to load-use on the EX entry.
module pipeline_hazard_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] instruction,
   input  logic        id_valid,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        stall_if_id,
   output logic        bubble_id_ex,
   output logic        flush_if_id,
   output logic        freeze,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       is_load;
      logic [3:0] rd;
   } sb_entry_t;

   state_t      state_q, state_d;
   sb_entry_t   sb_ex_q, sb_mem_q, sb_wb_q;
   sb_entry_t   id_entry;
   logic [15:0] stall_count_q;

   logic [3:0]  opcode, rd_f, rs1_f, rs2_f;
   logic        reads_rs1, reads_rs2, writes_rd, op_is_load;
   logic        hit_ex, hazard;

   logic        run_stall, run_bubble, run_flush, run_freeze;
   state_t      run_next;
   logic        stall_c, bubble_c, flush_c, freeze_c;

   assign opcode = instruction[19:16];
   assign rd_f   = instruction[15:12];
   assign rs1_f  = instruction[11:8];
   assign rs2_f  = instruction[7:4];

   // Opcodes 1100-1111 fall through to the NOP defaults.
   always_comb begin
      reads_rs1  = 1'b0;
      reads_rs2  = 1'b0;
      writes_rd  = 1'b0;
      op_is_load = 1'b0;
      if (opcode >= 4'h1 && opcode <= 4'h7) begin
         reads_rs1 = 1'b1;
         reads_rs2 = 1'b1;
         writes_rd = 1'b1;
      end else if (opcode == 4'h8) begin
         reads_rs1  = 1'b1;
         writes_rd  = 1'b1;
         op_is_load = 1'b1;
      end else if (opcode == 4'h9 || opcode == 4'hA) begin
         reads_rs1 = 1'b1;
         reads_rs2 = 1'b1;
      end
   end

   assign id_entry = '{valid: writes_rd, is_load: op_is_load, rd: rd_f};

   assign hit_ex = sb_ex_q.valid &&
                   ((reads_rs1 && sb_ex_q.rd == rs1_f) || (reads_rs2 && sb_ex_q.rd == rs2_f));

`ifdef HAZARD_FORWARD_EN
   logic unused_bits;
   assign unused_bits = ^sb_wb_q;
   assign hazard      = id_valid && hit_ex && sb_ex_q.is_load;
`else
   logic hit_mem, hit_wb;
   logic unused_bits;
   assign hit_mem = sb_mem_q.valid &&
                    ((reads_rs1 && sb_mem_q.rd == rs1_f) || (reads_rs2 && sb_mem_q.rd == rs2_f));
   assign hit_wb  = sb_wb_q.valid &&
                    ((reads_rs1 && sb_wb_q.rd == rs1_f) || (reads_rs2 && sb_wb_q.rd == rs2_f));
   assign unused_bits = sb_wb_q.is_load;
   assign hazard      = id_valid && (hit_ex || hit_mem || hit_wb);
`endif

   // RUN-state decision, also reused when a freeze releases.
   always_comb begin
      run_stall  = 1'b0;
      run_bubble = 1'b0;
      run_flush  = 1'b0;
      run_freeze = 1'b0;
      run_next   = ST_RUN;
      if (branch_taken) begin
         run_flush  = 1'b1;
         run_bubble = 1'b1;
         run_next   = ST_FLUSH;
      end else if (mem_busy) begin
         run_freeze = 1'b1;
         run_next   = ST_FREEZE;
      end else if (hazard) begin
         run_stall  = 1'b1;
         run_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      freeze_c = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (mem_busy) begin
               freeze_c = 1'b1;
               state_d  = ST_FREEZE;
            end else begin
               state_d  = ST_RUN;
            end
         end
         ST_FREEZE: begin
            if (mem_busy) begin
               freeze_c = 1'b1;
            end else begin
               stall_c  = run_stall;
               bubble_c = run_bubble;
               flush_c  = run_flush;
               freeze_c = run_freeze;
               state_d  = run_next;
            end
         end
         default: begin
            stall_c  = run_stall;
            bubble_c = run_bubble;
            flush_c  = run_flush;
            freeze_c = run_freeze;
            state_d  = run_next;
         end
      endcase
      if (reset) begin
         stall_c  = 1'b0;
         bubble_c = 1'b0;
         flush_c  = 1'b0;
         freeze_c = 1'b0;
         state_d  = ST_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_RUN;
         sb_ex_q       <= '0;
         sb_mem_q      <= '0;
         sb_wb_q       <= '0;
         stall_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (!freeze_c) begin
            sb_ex_q  <= (bubble_c || !id_valid) ? '0 : id_entry;
            sb_mem_q <= sb_ex_q;
            sb_wb_q  <= sb_mem_q;
         end
         if (stall_c && !freeze_c && stall_count_q != 16'hFFFF)
            stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign stall_if_id  = stall_c;
   assign bubble_id_ex = bubble_c;
   assign flush_if_id  = flush_c;
   assign freeze       = freeze_c;
   // The counter register only clears at the edge, so mask it during the reset cycle.
   assign stall_cycles = reset ? 16'h0000 : stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Expected outputs are hand-derived per build (HAZARD_FORWARD_EN selects the alternate column).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] instruction = '0;
   logic        id_valid = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_busy = 1'b0;
   logic        stall_if_id, bubble_id_ex, flush_if_id, freeze;
   logic [15:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        rst, idv, br, mb;
      logic [19:0] instr;
      logic [19:0] exp;
   } row_t;

   row_t        rows[$];
   logic [19:0] exp_q[$];

   pipeline_hazard_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .instruction  (instruction),
      .id_valid     (id_valid),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .stall_if_id  (stall_if_id),
      .bubble_id_ex (bubble_id_ex),
      .flush_if_id  (flush_if_id),
      .freeze       (freeze),
      .stall_cycles (stall_cycles)
   );

   always #5 clock = ~clock;

   function automatic logic [19:0] ins(input logic [3:0] op, rd, rs1, rs2);
      return {op, rd, rs1, rs2, 4'h0};
   endfunction

   function automatic logic [19:0] o(input logic s, b, f, z, input logic [15:0] c);
      return {s, b, f, z, c};
   endfunction

   function automatic row_t mk(input logic rst, idv, br, mb, input logic [19:0] instr,
                               input logic [19:0] exp);
      row_t r;
      r.rst = rst; r.idv = idv; r.br = br; r.mb = mb; r.instr = instr; r.exp = exp;
      return r;
   endfunction

   task automatic apply(input row_t r);
      reset        = r.rst;
      id_valid     = r.idv;
      branch_taken = r.br;
      mem_busy     = r.mb;
      instruction  = r.instr;
   endtask

   task automatic test_reset();
      logic [19:0] got, want;
      rows.delete();
      rows.push_back(mk(1, 1, 1, 1, ins(1, 3, 3, 3), o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, ins(0, 0, 0, 0), o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(7, 2, 1, 1), o(0, 0, 0, 0, 0)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_alu_dep();
      logic [19:0] got, want, a, b;
      a = ins(1, 3, 1, 2);
      b = ins(1, 4, 3, 0);
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, a, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 1)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 2)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(0, 0, 0, 0, 3)));
      rows.push_back(mk(0, 0, 0, 0, '0, FWD ? o(0, 0, 0, 0, 0) : o(0, 0, 0, 0, 3)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL alu_dep row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_load_use();
      logic [19:0] got, want, l, d;
      l = ins(8, 5, 1, 0);
      d = ins(2, 6, 1, 5);
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, l, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, d, o(1, 1, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, d, FWD ? o(0, 0, 0, 0, 1) : o(1, 1, 0, 0, 1)));
      rows.push_back(mk(0, 1, 0, 0, d, FWD ? o(0, 0, 0, 0, 1) : o(1, 1, 0, 0, 2)));
      rows.push_back(mk(0, 1, 0, 0, d, FWD ? o(0, 0, 0, 0, 1) : o(0, 0, 0, 0, 3)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL load_use row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   // Non-reading opcodes, register 0 as a real register, and id_valid gating.
   task automatic test_decode();
      logic [19:0] got, want;
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(7, 7, 1, 2), o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(11, 7, 7, 7), o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(12, 7, 7, 7), o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(8, 0, 7, 0), FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, ins(8, 0, 7, 0), FWD ? o(0, 0, 0, 0, 0) : o(0, 0, 0, 0, 1)));
      rows.push_back(mk(0, 1, 0, 0, ins(9, 0, 1, 0), FWD ? o(1, 1, 0, 0, 0) : o(1, 1, 0, 0, 1)));
      rows.push_back(mk(0, 0, 0, 0, ins(9, 0, 1, 0), FWD ? o(0, 0, 0, 0, 1) : o(0, 0, 0, 0, 2)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL decode row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_branch();
      logic [19:0] got, want, a, b;
      logic [15:0] c;
      a = ins(1, 3, 1, 2);
      b = ins(1, 4, 3, 0);
      c = FWD ? 16'd0 : 16'd1;
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, a, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 1, 0, b, o(0, 1, 1, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, b, o(0, 1, 1, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 0, 0, 0, c)));
      rows.push_back(mk(0, 0, 1, 0, '0, o(0, 1, 1, 0, c)));
      rows.push_back(mk(0, 0, 0, 1, '0, o(0, 1, 1, 1, c)));
      rows.push_back(mk(0, 0, 1, 1, '0, o(0, 0, 0, 1, c)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 0, 0, 0, c)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 0, 0, 0, c)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL branch row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_mem_freeze();
      logic [19:0] got, want, a, b;
      logic [15:0] c;
      a = ins(1, 3, 1, 2);
      b = ins(1, 9, 3, 3);
      c = FWD ? 16'd0 : 16'd1;
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, a, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 0)));
      for (int k = 0; k < 4; k++)
         rows.push_back(mk(0, 1, 0, 1, b, o(0, 0, 0, 1, c)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 1)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(1, 1, 0, 0, 2)));
      rows.push_back(mk(0, 1, 0, 0, b, FWD ? o(0, 0, 0, 0, 0) : o(0, 0, 0, 0, 3)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL mem_freeze row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] got, want;
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 0, 1, 0, '0, o(0, 1, 1, 0, 0)));
      rows.push_back(mk(1, 0, 1, 1, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 0, 0, 1, '0, o(0, 0, 0, 1, 0)));
      rows.push_back(mk(1, 0, 0, 1, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 0, 1, 1, '0, o(0, 1, 1, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 1, 1, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
      end
   endtask

   // The counter is preloaded near the top so saturation is reached in a few cycles.
   task automatic test_saturate();
      logic [19:0] got, want, l;
      l = ins(8, 5, 5, 0);
      rows.delete();
      rows.push_back(mk(1, 0, 0, 0, '0, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, l, o(0, 0, 0, 0, 16'hFFFD)));
      rows.push_back(mk(0, 1, 0, 0, l, o(1, 1, 0, 0, 16'hFFFD)));
      rows.push_back(mk(0, 1, 0, 0, l, FWD ? o(0, 0, 0, 0, 16'hFFFE) : o(1, 1, 0, 0, 16'hFFFE)));
      rows.push_back(mk(0, 1, 0, 0, l, FWD ? o(1, 1, 0, 0, 16'hFFFE) : o(1, 1, 0, 0, 16'hFFFF)));
      rows.push_back(mk(0, 1, 0, 0, l, o(0, 0, 0, 0, 16'hFFFF)));
      rows.push_back(mk(0, 1, 0, 0, l, o(1, 1, 0, 0, 16'hFFFF)));
      rows.push_back(mk(1, 1, 0, 0, l, o(0, 0, 0, 0, 0)));
      rows.push_back(mk(0, 1, 0, 0, l, o(0, 0, 0, 0, 0)));
      for (int i = 0; i < rows.size(); i++) begin
         if (i == 1)
            force dut.stall_count_q = 16'hFFFD;
         apply(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clock);
         got  = {stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL saturate row%0d got=%h want=%h", i, got, want);
         end
         @(posedge clock); #1;
         if (i == 1)
            release dut.stall_count_q;
      end
   endtask

   initial begin
      @(posedge clock); #1;
      test_reset();
      test_alu_dep();
      test_load_use();
      test_decode();
      test_branch();
      test_mem_freeze();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
